avalon_msg_transmitter: RTL

Master-side source of Avalon-ST messages: the transmit end of the protocol that avalon_st_if slaves (enforcers, consumers) check.
- Takes a message command (byte length) and a raw word stream.
- Emits a protocol-correct message on an avalon_st_if.master: exactly one sop, exactly one eop, correct empty, no gaps inside a beat, honouring rdy backpressure.
- Sits between internal message producers and any downstream Avalon-ST consumer.

---
 rtl/avalon_msg_tx_pack.sv | 19 +
 rtl/avalon_st_if.sv | 16 +
 rtl/avalon_st_out_reg.sv | 44 ++++
 rtl/avalon_msg_transmitter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/avalon_msg_tx_pack.sv
// Shared types and helpers for the Avalon-ST message transmitter.
package avalon_msg_tx_pack;

  typedef enum logic [0:0] {
    WAIT_FOR_CMD,
    SEND_MESSAGE
  } avalon_msg_tx_sm_t;

  // Ceiling log2, never less than 1 so that derived widths stay legal.
  function automatic int unsigned log2up_func(input int unsigned value);
    int unsigned res;
    res = 1;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST message stream: one beat per valid & rdy, sop/eop framing, empty on the eop beat.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16
);
  localparam int unsigned EMPTY_WIDTH = avalon_msg_tx_pack::log2up_func(DATA_WIDTH_IN_BYTES);

  logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_WIDTH-1:0]           empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_out_reg.sv
// One-stage Avalon-ST output register: loads when empty or draining, holds under backpressure.
module avalon_st_out_reg import avalon_msg_tx_pack::*; #(
  parameter  int unsigned DATA_WIDTH_IN_BYTES = 16,
  localparam int unsigned EMPTY_WIDTH         = log2up_func(DATA_WIDTH_IN_BYTES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [DATA_WIDTH_IN_BYTES*8-1:0] load_data,
  input  logic                             load_sop,
  input  logic                             load_eop,
  input  logic [EMPTY_WIDTH-1:0]           load_empty,
  output logic                             load_rdy,
  input  logic                             rdy,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0] data,
  output logic                             valid,
  output logic                             sop,
  output logic                             eop,
  output logic [EMPTY_WIDTH-1:0]           empty
);

  // Free slot this cycle if nothing is held or the held beat transfers now.
  assign load_rdy = ~valid | rdy;

  // Load a new beat, otherwise clear valid once the held beat has transferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
      sop   <= 1'b0;
      eop   <= 1'b0;
      empty <= '0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      sop   <= load_sop;
      eop   <= load_eop;
      empty <= load_empty;
    end else if (rdy) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avalon_msg_transmitter.sv
// Turns a (length, word stream) pair into one framed Avalon-ST message.
module avalon_msg_transmitter import avalon_msg_tx_pack::*; #(
  parameter  int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter  int unsigned MAX_MSG_LEN_BYTES   = 4096,
  localparam int unsigned LEN_WIDTH           = log2up_func(MAX_MSG_LEN_BYTES + 1),
  localparam int unsigned EMPTY_WIDTH         = log2up_func(DATA_WIDTH_IN_BYTES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  input  logic [LEN_WIDTH-1:0]             cmd_len,
  output logic                             cmd_rdy,
  input  logic                             word_valid,
  input  logic [DATA_WIDTH_IN_BYTES*8-1:0] word_data,
  output logic                             word_rdy,
  avalon_st_if.master                      tx_msg,
  output logic                             len_error,
  output logic                             msg_done,
  output logic                             busy
);

  localparam logic [LEN_WIDTH-1:0] BYTES = LEN_WIDTH'(DATA_WIDTH_IN_BYTES);

  avalon_msg_tx_sm_t      state;
  logic [LEN_WIDTH-1:0]   word_cnt;
  logic [LEN_WIDTH-1:0]   words_total;
  logic [EMPTY_WIDTH-1:0] last_empty;

  logic [LEN_WIDTH:0]     len_round;
  logic [LEN_WIDTH-1:0]   len_rem;
  logic [LEN_WIDTH-1:0]   cmd_words;
  logic [EMPTY_WIDTH-1:0] cmd_empty;
  logic                   cmd_len_ok;
  logic                   cmd_acc;
  logic                   word_acc;
  logic                   last_word;
  logic                   out_load_rdy;
  logic                   eop_xfer;

  logic [DATA_WIDTH_IN_BYTES*8-1:0] out_data;
  logic                             out_valid;
  logic                             out_sop;
  logic                             out_eop;
  logic [EMPTY_WIDTH-1:0]           out_empty;

  // Command decode: beat count and unused bytes of the final beat.
  assign len_round  = {1'b0, cmd_len} + (LEN_WIDTH + 1)'(DATA_WIDTH_IN_BYTES - 1);
  assign cmd_words  = LEN_WIDTH'(len_round / (LEN_WIDTH + 1)'(DATA_WIDTH_IN_BYTES));
  assign len_rem    = cmd_len % BYTES;
  assign cmd_empty  = EMPTY_WIDTH'((BYTES - len_rem) % BYTES);
  assign cmd_len_ok = (cmd_len != '0) && (cmd_len <= LEN_WIDTH'(MAX_MSG_LEN_BYTES));

  assign cmd_acc   = cmd_valid & cmd_rdy & (state == WAIT_FOR_CMD);
  assign word_rdy  = (state == SEND_MESSAGE) & out_load_rdy;
  assign word_acc  = word_valid & word_rdy;
  assign last_word = (word_cnt == words_total - LEN_WIDTH'(1));
  assign eop_xfer  = out_valid & tx_msg.rdy & out_eop;

  avalon_st_out_reg #(
    .DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (word_acc),
    .load_data (word_data),
    .load_sop  (word_cnt == '0),
    .load_eop  (last_word),
    .load_empty(last_word ? last_empty : '0),
    .load_rdy  (out_load_rdy),
    .rdy       (tx_msg.rdy),
    .data      (out_data),
    .valid     (out_valid),
    .sop       (out_sop),
    .eop       (out_eop),
    .empty     (out_empty)
  );

  assign tx_msg.data  = out_data;
  assign tx_msg.valid = out_valid;
  assign tx_msg.sop   = out_sop;
  assign tx_msg.eop   = out_eop;
  assign tx_msg.empty = out_empty;

  // Command/word sequencing with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_FOR_CMD;
      cmd_rdy     <= 1'b0;
      len_error   <= 1'b0;
      msg_done    <= 1'b0;
      busy        <= 1'b0;
      word_cnt    <= '0;
      words_total <= '0;
      last_empty  <= '0;
    end else begin
      len_error <= 1'b0;
      msg_done  <= eop_xfer;
      // A newer message already in flight keeps busy high past the old eop.
      if (eop_xfer && (state == WAIT_FOR_CMD)) begin
        busy <= 1'b0;
      end
      unique case (state)
        WAIT_FOR_CMD: begin
          cmd_rdy <= 1'b1;
          if (cmd_acc) begin
            if (cmd_len_ok) begin
              words_total <= cmd_words;
              last_empty  <= cmd_empty;
              word_cnt    <= '0;
              busy        <= 1'b1;
              cmd_rdy     <= 1'b0;
              state       <= SEND_MESSAGE;
            end else begin
              len_error <= 1'b1;
            end
          end
        end
        SEND_MESSAGE: begin
          cmd_rdy <= 1'b0;
          if (word_acc) begin
            word_cnt <= word_cnt + LEN_WIDTH'(1);
            if (last_word) begin
              cmd_rdy <= 1'b1;
              state   <= WAIT_FOR_CMD;
            end
          end
        end
        default: state <= WAIT_FOR_CMD;
      endcase
    end
  end

endmodule
